rom_loader: RTL and testbench

- Write-side counterpart to the instruction ROM read path. The CPU fetches instruction words from ROM; this block writes them.
- Accepts a framed byte stream over a valid/ready handshake, from a UART RX or debug bridge. Assembles 16-bit Hack instruction words and writes them sequentially into ROM32K from address 0.
- Holds the CPU in reset while loading and releases it only after a verified load.

---
 rtl/rom_loader.sv | 197 +++++++++++++++++++
 tb/tb_rom_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Framed byte-stream loader that writes Hack instruction words into ROM.
// Holds the CPU in reset until a length- and checksum-verified load completes.
module rom_loader #(
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              we_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [15:0]       rom_data_d;
  logic              cpu_reset_d;
  logic              done_d;
  logic              error_d;
  logic [1:0]        err_code_d;
  logic [15:0]       wc_d;

  logic              active;
  logic              xfer;
  logic              tmo_hit;
  logic [15:0]       n_len;

  always_comb begin
    active = 1'b0;
    unique case (1'b1)
      state_q == S_CNT_HI,
      state_q == S_CNT_LO,
      state_q == S_DAT_HI,
      state_q == S_DAT_LO,
      state_q == S_CHK: active = 1'b1;
      default: active = 1'b0;
    endcase
  end

  assign rx_ready = active;
  assign busy     = active;
  assign xfer     = rx_valid && active;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign n_len    = {len_q[15:8], rx_data};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    rom_addr_d  = rom_addr;
    rom_data_d  = rom_data;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    error_d     = error;
    err_code_d  = err_code;
    wc_d        = word_count;

    if (!active) begin
      if (start) begin
        state_d     = S_CNT_HI;
        addr_d      = '0;
        rom_addr_d  = '0;
        wc_d        = '0;
        sum_d       = '0;
        tmo_d       = '0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        err_code_d  = 2'b00;
        cpu_reset_d = 1'b1;
      end
    end else if (xfer) begin
      // A transfer always beats a timeout landing in the same cycle
      tmo_d = '0;
      sum_d = sum_q + rx_data;
      unique case (state_q)
        S_CNT_HI: begin
          len_d[15:8] = rx_data;
          state_d     = S_CNT_LO;
        end
        S_CNT_LO: begin
          len_d = n_len;
          if (n_len == 16'd0 ||
              32'(n_len) > (32'd1 << ADDR_W)) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = 2'b01;
          end else begin
            state_d = S_DAT_HI;
          end
        end
        S_DAT_HI: begin
          hi_d    = rx_data;
          state_d = S_DAT_LO;
        end
        S_DAT_LO: begin
          we_d       = 1'b1;
          rom_data_d = {hi_q, rx_data};
          rom_addr_d = addr_q;
          addr_d     = addr_q + ADDR_W'(1);
          wc_d       = word_count + 16'd1;
          if (word_count + 16'd1 == len_q)
            state_d = S_CHK;
          else
            state_d = S_DAT_HI;
        end
        S_CHK: begin
          sum_d = sum_q;
          if (rx_data == sum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = 2'b10;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (tmo_hit) begin
      state_d    = S_ERR;
      error_d    = 1'b1;
      err_code_d = 2'b11;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      rom_we     <= we_d;
      rom_addr   <= rom_addr_d;
      rom_data   <= rom_data_d;
      cpu_reset  <= cpu_reset_d;
      done       <= done_d;
      error      <= error_d;
      err_code   <= err_code_d;
      word_count <= wc_d;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: frames, errors, gaps, timeout, reset.
// ROM writes are logged at the falling edge and checked per scenario.
module tb_rom_loader;

  localparam int AW = 15;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [15:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [AW+15:0] wlog[$];

  rom_loader #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rom_we(rom_we),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (rom_we) wlog.push_back({rom_addr, rom_data});

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 16) begin
      tick();
      n++;
    end
    chk("ready", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flags"},
        {rx_ready, rom_we, cpu_reset, busy, done, error, err_code},
        8'b0010_0000);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_data"}, rom_data, 0);
    chk({tag, "_wc"}, word_count, 0);
  endtask

  task automatic send_frame_ok();
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
    send(8'hC0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();

    // Valid two-word load
    wlog.delete();
    pulse_start();
    chk("busy_after_start", {busy, rx_ready}, 2'b11);
    send_frame_ok();
    chk("ok_done", {done, error, cpu_reset, busy}, 4'b1000);
    chk("ok_code", err_code, 0);
    chk("ok_wc", word_count, 2);
    chk("ok_nw", wlog.size(), 2);
    chk("ok_w0", wlog[0], {15'd0, 16'h1234});
    chk("ok_w1", wlog[1], {15'd1, 16'hABCD});

    // Restart from DONE, start ignored mid-word
    wlog.delete();
    pulse_start();
    chk("rs_clear", {done, cpu_reset, busy}, 3'b011);
    chk("rs_wc", word_count, 0);
    send(8'h00); send(8'h01); send(8'h55);
    pulse_start();
    chk("ign_busy", {busy, rx_ready, done}, 3'b110);
    chk("ign_nw", wlog.size(), 0);
    send(8'h66);
    send(8'hBC);
    chk("rs_done", {done, error, cpu_reset}, 3'b100);
    chk("rs_wc1", word_count, 1);
    chk("rs_nw", wlog.size(), 1);
    chk("rs_w0", wlog[0], {15'd0, 16'h5566});

    // Bad checksum
    wlog.delete();
    pulse_start();
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
    send(8'hC1);
    chk("chk_flags", {done, error, cpu_reset, busy}, 4'b0110);
    chk("chk_code", err_code, 2'b10);
    chk("chk_nw", wlog.size(), 2);
    chk("chk_rdy", rx_ready, 0);

    // Bad length N=0
    wlog.delete();
    pulse_start();
    chk("len0_clr", {error, err_code}, 3'b000);
    send(8'h00); send(8'h00);
    chk("len0_err", {error, err_code, busy}, 4'b1010);

    // Bad length N=32769
    pulse_start();
    send(8'h80); send(8'h01);
    chk("lenbig_err", {error, err_code, busy}, 4'b1010);
    chk("len_nw", wlog.size(), 0);

    // N=32768 is the largest legal length
    pulse_start();
    send(8'h80); send(8'h00);
    chk("lenmax_ok", {error, busy, rx_ready}, 3'b011);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Seven-cycle gaps between every byte
    wlog.delete();
    pulse_start();
    repeat (7) tick(); send(8'h00);
    repeat (7) tick(); send(8'h01);
    repeat (7) tick(); send(8'h0F);
    repeat (7) tick(); send(8'hF0);
    repeat (7) tick(); send(8'h00);
    chk("gap_done", {done, error, cpu_reset}, 3'b100);
    chk("gap_nw", wlog.size(), 1);
    chk("gap_w0", wlog[0], {15'd0, 16'h0FF0});

    // Stall after the third byte
    wlog.delete();
    pulse_start();
    send(8'h00); send(8'h01); send(8'h0A);
    repeat (9) tick();
    chk("tmo_flags", {done, error, cpu_reset, busy}, 4'b0110);
    chk("tmo_code", err_code, 2'b11);
    chk("tmo_nw", wlog.size(), 0);
    chk("tmo_wc", word_count, 0);

    // Reset in the middle of word 1
    pulse_start();
    send(8'h00); send(8'h02);
    send(8'h11); send(8'h22);
    send(8'h33);
    reset = 1'b0;
    tick();
    chk_reset_vals("mid");
    reset = 1'b1;
    tick();
    wlog.delete();
    pulse_start();
    send_frame_ok();
    chk("rl_done", {done, error, cpu_reset}, 3'b100);
    chk("rl_nw", wlog.size(), 2);
    chk("rl_w0", wlog[0], {15'd0, 16'h1234});
    chk("rl_w1", wlog[1], {15'd1, 16'hABCD});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
